// File: rtl/vco_array.sv
// vco_array -- multi-channel digital VCO behavioural model.
//
// Each channel turns an unsigned control word into a phase increment via
// T = F0 + K*v_in (saturated to the accumulator range) and integrates that
// increment in a wrapping phase accumulator. In glide mode the increment
// register slews toward T by at most SLEW per cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active low
//   v_in    packed control words, channel c at [c*V_W +: V_W]
//   en      per-channel accumulate enable
//   glide   1 = slew-limited tuning on all channels, 0 = direct tuning
//   v_out   packed phase accumulators, channel c at [c*ACC_W +: ACC_W]
//   sq_out  MSB of each channel's accumulator
//   wrap    one-cycle pulse on accumulator overflow, per channel
module vco_array #(
  parameter int unsigned      N_CH  = 2,
  parameter int unsigned      V_W   = 8,
  parameter int unsigned      ACC_W = 25,
  parameter logic [ACC_W-1:0] F0    = '0,
  parameter int unsigned      K     = 1,
  parameter int unsigned      SLEW  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*V_W-1:0]     v_in,
  input  logic [N_CH-1:0]         en,
  input  logic                    glide,
  output logic [N_CH*ACC_W-1:0]   v_out,
  output logic [N_CH-1:0]         sq_out,
  output logic [N_CH-1:0]         wrap
);

  // Working width for the tuning law: wide enough for F0 + K*v_in without
  // overflow (K is a 32-bit multiplier), plus one guard bit.
  localparam int unsigned PW = V_W + 32;
  localparam int unsigned TW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  localparam logic [TW-1:0] INC_MAX = TW'({ACC_W{1'b1}});
  localparam logic [TW-1:0] SLEW_T  = TW'(SLEW);

  logic [ACC_W-1:0] acc_q [N_CH];
  logic [ACC_W-1:0] acc_d [N_CH];
  logic [ACC_W-1:0] inc_q [N_CH];
  logic [ACC_W-1:0] inc_d [N_CH];
  logic [N_CH-1:0]  wrap_q;
  logic [N_CH-1:0]  wrap_d;

  logic [TW-1:0]    tgt;
  logic [TW-1:0]    cur;
  logic [TW-1:0]    nxt;
  logic [ACC_W:0]   sum;

  always_comb begin
    tgt    = '0;
    cur    = '0;
    nxt    = '0;
    sum    = '0;
    wrap_d = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      acc_d[c] = acc_q[c];
      inc_d[c] = inc_q[c];

      // Target increment, saturated rather than wrapped.
      tgt = TW'(F0) + TW'(K) * TW'(v_in[c*V_W +: V_W]);
      if (tgt > INC_MAX) begin
        tgt = INC_MAX;
      end

      // Increment register: direct load, or a bounded step toward target.
      // It retunes regardless of en so a paused channel keeps tracking.
      cur = TW'(inc_q[c]);
      if (!glide) begin
        nxt = tgt;
      end else if (tgt > cur) begin
        nxt = ((tgt - cur) > SLEW_T) ? (cur + SLEW_T) : tgt;
      end else begin
        nxt = ((cur - tgt) > SLEW_T) ? (cur - SLEW_T) : tgt;
      end
      inc_d[c] = nxt[ACC_W-1:0];

      // Phase accumulator integrates the increment held before this edge,
      // so a new increment first shows up one edge after it is loaded.
      if (en[c]) begin
        sum       = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
        acc_d[c]  = sum[ACC_W-1:0];
        wrap_d[c] = sum[ACC_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        acc_q[c] <= '0;
        inc_q[c] <= '0;
      end
      wrap_q <= '0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        acc_q[c] <= acc_d[c];
        inc_q[c] <= inc_d[c];
      end
      wrap_q <= wrap_d;
    end
  end

  // Outputs are pure register taps.
  always_comb begin
    v_out  = '0;
    sq_out = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      v_out[c*ACC_W +: ACC_W] = acc_q[c];
      sq_out[c]               = acc_q[c][ACC_W-1];
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_vco_array.sv
// Testbench for vco_array: three instances (default, narrow 12-bit with K=2
// and odd slew, and a saturating F0) checked every cycle against a
// behavioural model, plus directed checks for reset release, wrap period,
// glide ramps, enable gaps and reset during glide.
module tb_vco_array;

  logic        clk;
  logic        rst;
  logic        glide;
  logic [15:0] vin [3];
  logic [1:0]  ena [3];

  logic [49:0] vo0;
  logic [23:0] vo1;
  logic [49:0] vo2;
  logic [1:0]  sq0, sq1, sq2;
  logic [1:0]  wr0, wr1, wr2;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-instance parameters as seen by the model.
  localparam longint PW  [3] = '{64'd25, 64'd12, 64'd25};
  localparam longint PF0 [3] = '{64'd0, 64'd0, 64'd33554332};
  localparam longint PK  [3] = '{64'd1, 64'd2, 64'd1};
  localparam longint PS  [3] = '{64'd16, 64'd7, 64'd16};

  longint m_acc  [3][2];
  longint m_inc  [3][2];
  longint m_wrap [3][2];

  vco_array u_main (
    .clk(clk), .rst(rst), .v_in(vin[0]), .en(ena[0]), .glide(glide),
    .v_out(vo0), .sq_out(sq0), .wrap(wr0)
  );

  vco_array #(.N_CH(2), .V_W(8), .ACC_W(12), .F0(12'd0), .K(2), .SLEW(7)) u_small (
    .clk(clk), .rst(rst), .v_in(vin[1]), .en(ena[1]), .glide(glide),
    .v_out(vo1), .sq_out(sq1), .wrap(wr1)
  );

  vco_array #(.N_CH(2), .V_W(8), .ACC_W(25), .F0(25'd33554332), .K(1), .SLEW(16)) u_sat (
    .clk(clk), .rst(rst), .v_in(vin[2]), .en(ena[2]), .glide(glide),
    .v_out(vo2), .sq_out(sq2), .wrap(wr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic longint obs_acc(input int i, input int ch);
    case (i)
      0:       return longint'(vo0[ch*25 +: 25]);
      1:       return longint'(vo1[ch*12 +: 12]);
      default: return longint'(vo2[ch*25 +: 25]);
    endcase
  endfunction

  function automatic longint obs_sq(input int i, input int ch);
    case (i)
      0:       return longint'(sq0[ch]);
      1:       return longint'(sq1[ch]);
      default: return longint'(sq2[ch]);
    endcase
  endfunction

  function automatic longint obs_wr(input int i, input int ch);
    case (i)
      0:       return longint'(wr0[ch]);
      1:       return longint'(wr1[ch]);
      default: return longint'(wr2[ch]);
    endcase
  endfunction

  // One clock: advance the model on the inputs present at the edge, then
  // compare every output of every instance shortly after the edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        longint mask, t, d, s;
        mask = (64'd1 << PW[i]) - 1;
        if (!rst) begin
          m_acc[i][ch]  = 0;
          m_inc[i][ch]  = 0;
          m_wrap[i][ch] = 0;
        end else begin
          if (ena[i][ch]) begin
            s = m_acc[i][ch] + m_inc[i][ch];
            m_wrap[i][ch] = (s > mask) ? 1 : 0;
            m_acc[i][ch]  = s & mask;
          end else begin
            m_wrap[i][ch] = 0;
          end
          t = PF0[i] + PK[i] * longint'(vin[i][ch*8 +: 8]);
          if (t > mask) t = mask;
          if (!glide) begin
            m_inc[i][ch] = t;
          end else begin
            d = t - m_inc[i][ch];
            if (d > PS[i]) d = PS[i];
            if (d < -PS[i]) d = -PS[i];
            m_inc[i][ch] = m_inc[i][ch] + d;
          end
        end
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        check($sformatf("acc%0d.%0d", i, ch), obs_acc(i, ch), m_acc[i][ch]);
        check($sformatf("sq%0d.%0d", i, ch), obs_sq(i, ch), (m_acc[i][ch] >> (PW[i] - 1)) & 1);
        check($sformatf("wrap%0d.%0d", i, ch), obs_wr(i, ch), m_wrap[i][ch]);
      end
    end
  endtask

  initial begin
    longint mask25;
    longint a_prev, a, f, b_prev, b;
    int     last_wrap, n_wrap_ch1, n_sq;

    mask25 = (64'd1 << 25) - 1;
    for (int i = 0; i < 3; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_acc[i][ch] = 0; m_inc[i][ch] = 0; m_wrap[i][ch] = 0;
      end
    end

    // Reset with main ch0 = 0x80, small ch0 = 64, sat ch0 = 255.
    rst    = 1'b0;
    glide  = 1'b0;
    vin[0] = 16'h0080;
    vin[1] = 16'h0040;
    vin[2] = 16'h00FF;
    ena[0] = 2'b11; ena[1] = 2'b11; ena[2] = 2'b11;
    tick();
    tick();
    check("rst_vout", obs_acc(0, 0), 0);
    check("rst_sq",   obs_sq(0, 0), 0);
    check("rst_wrap", obs_wr(0, 0), 0);

    rst = 1'b1;
    check("rel0", obs_acc(0, 0), 0);
    tick();
    check("rel1", obs_acc(0, 0), 0);
    tick();
    check("rel2", obs_acc(0, 0), 128);
    check("sat_inc", obs_acc(2, 0), mask25);
    check("sat_nowrap_first", obs_wr(2, 0), 0);
    tick();
    check("rel3", obs_acc(0, 0), 256);
    check("sat_wrap_second", obs_wr(2, 0), 1);

    // Saturated increment: wraps every cycle, phase steps by -1.
    a_prev = obs_acc(2, 0);
    for (int j = 0; j < 20; j++) begin
      tick();
      a = obs_acc(2, 0);
      check("sat_wrap", obs_wr(2, 0), 1);
      check("sat_step", (a_prev - a) & mask25, 1);
      a_prev = a;
    end

    // Wrap period on the 12-bit instance: inc = 2*64 = 128, period 32.
    last_wrap  = -1;
    n_wrap_ch1 = 0;
    n_sq       = 0;
    for (int j = 0; j < 256; j++) begin
      tick();
      if (wr1[0]) begin
        if (last_wrap >= 0) check("wrap_period", j - last_wrap, 32);
        last_wrap = j;
      end
      if (wr1[1]) n_wrap_ch1++;
      if (sq1[0]) n_sq++;
    end
    check("sq_duty", n_sq, 128);
    check("ch1_nowrap", n_wrap_ch1, 0);

    // Glide up 0 -> 128 and back down on main ch0.
    vin[0] = 16'h0000;
    tick();
    tick();
    glide  = 1'b1;
    vin[0] = 16'h0080;
    a_prev = obs_acc(0, 0);
    for (int j = 1; j <= 10; j++) begin
      longint e;
      tick();
      a = obs_acc(0, 0);
      e = 16 * (j - 1);
      if (e > 128) e = 128;
      check("glide_up", (a - a_prev) & mask25, e);
      a_prev = a;
    end
    vin[0] = 16'h0000;
    for (int j = 1; j <= 10; j++) begin
      longint e;
      tick();
      a = obs_acc(0, 0);
      e = 128 - 16 * (j - 1);
      if (e < 0) e = 0;
      check("glide_down", (a - a_prev) & mask25, e);
      a_prev = a;
    end

    // Enable gap on ch0 while ch1 keeps running.
    glide  = 1'b0;
    vin[0] = 16'h25C8;
    for (int j = 0; j < 5; j++) tick();
    f      = obs_acc(0, 0);
    b_prev = obs_acc(0, 1);
    ena[0] = 2'b10;
    for (int j = 0; j < 10; j++) begin
      tick();
      b = obs_acc(0, 1);
      check("gap_frozen", obs_acc(0, 0), f);
      check("gap_wrap", obs_wr(0, 0), 0);
      check("gap_ch1", (b - b_prev) & mask25, 37);
      b_prev = b;
    end
    ena[0] = 2'b11;
    tick();
    check("gap_resume", obs_acc(0, 0), (f + 200) & mask25);

    // Reset while ch0 is halfway up a glide.
    vin[0] = 16'h0000;
    tick();
    tick();
    glide  = 1'b1;
    vin[0] = 16'h0080;
    for (int j = 0; j < 4; j++) tick();
    rst = 1'b0;
    tick();
    check("midrst_acc", obs_acc(0, 0), 0);
    rst = 1'b1;
    tick();
    check("midrst_r1", obs_acc(0, 0), 0);
    tick();
    check("midrst_r2", obs_acc(0, 0), 16);
    tick();
    check("midrst_r3", obs_acc(0, 0), 48);

    // Randomized run across all instances.
    for (int j = 0; j < 1500; j++) begin
      for (int i = 0; i < 3; i++) begin
        vin[i] = 16'($urandom);
        ena[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      end
      if ($urandom_range(0, 31) == 0) glide = ~glide;
      rst = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vco_array.md
# vco_array

Parametrised multi-channel digital VCO behavioural model: each channel converts an unsigned control word into a phase increment via an affine tuning law, then integrates it in a wrapping phase accumulator. It is the multi-channel successor of the single-channel `vco_model` (8-bit control in, 25-bit phase out) and adds:

- an optional slew-limited "glide" mode;
- per-channel enables;
- wrap pulses and square-wave outputs, for use as a clock/phase source by downstream PLL and ADC models.

## Interface

Parameters:

- `N_CH`, 2, number of independent channels
- `V_W`, 8, control word width per channel
- `ACC_W`, 25, phase accumulator width per channel
- `F0`, 0, base increment (free-running frequency word), ACC_W bits
- `K`, 1, tuning gain, unsigned integer multiplier on `v_in`
- `SLEW`, 16, maximum change of the increment per cycle in glide mode; must be ≥ 1

Ports:

- `clk` input 1: clock; all state updates on the rising edge
- `rst` input 1: synchronous, active-low reset (asserted when 0)
- `v_in` input N_CH*V_W: packed control words, channel c at `[c*V_W +: V_W]`
- `en` input N_CH: per-channel accumulate enable
- `glide` input 1: 0 means direct tuning, 1 means slew-limited tuning (all channels)
- `v_out` output N_CH*ACC_W: packed phase accumulators, channel c at `[c*ACC_W +: ACC_W]`
- `sq_out` output N_CH: MSB of each channel's accumulator
- `wrap` output N_CH: one-cycle pulse when a channel's accumulator overflows

## Operation

- Per channel, the target increment is T = F0 + K*v_in[c].
  - Compute it at full width, then saturate to 2^ACC_W − 1.
- Each channel has an increment register `inc`.
  - `glide`=0: `inc` ← T.
  - `glide`=1: if |T − inc| ≤ SLEW, `inc` ← T; otherwise `inc` moves toward T by exactly SLEW.
  - `inc` updates every cycle regardless of `en`, so retuning continues while a channel is paused.
- Phase accumulator `acc`, per channel:
  - `en`=1: `acc` ← (acc + inc) mod 2^ACC_W, and `wrap` ← carry-out of that addition.
  - `en`=0: `acc` holds and `wrap` ← 0.
- `v_out` = `acc`; `sq_out` = acc[ACC_W−1]. Both are direct register outputs with no combinational path from inputs.
- Channels are fully independent; only `glide` is shared.
- Toggling `glide` mid-slew:
  - switching to 0: `inc` jumps to T on the next edge;
  - switching to 1: slewing begins from the current `inc`.
- `inc` = 0 with `en`=1 is legal: the accumulator holds and `wrap` stays 0.
- `inc` = 2^ACC_W − 1 wraps on every cycle except the first after reset (`acc` = 0 → 2^ACC_W − 1 produces no carry). From the second cycle on, `wrap` = 1 continuously.

## Timing

- Reset: on any rising edge with `rst`=0, all of the following clear to 0 on that edge:
  - `acc`, `inc`, `wrap`;
  - therefore `v_out`, `sq_out`, `wrap` all read 0.
  - Reset mid-operation discards phase and glide progress; nothing is retained.
- First cycle after `rst` rises:
  - `inc` loads from the current `v_in`;
  - `acc` adds the old `inc` (0), so `v_out` stays 0 for that cycle.
- Latency, `glide`=0: a change on `v_in` at edge k is in `inc` after edge k. It first advances `acc` at edge k+1, i.e. 2 edges from the input change to the first step at the new rate.
- Glide settling: reaching T from a distance D takes ceil(D/SLEW) edges.
- `wrap` asserts in the same cycle that `v_out` shows the post-overflow value.
- `en` is sampled at the edge: `en`=0 at edge k means `acc`(k) = `acc`(k−1).

## Test plan

1. **Reset.** Hold `rst`=0 for 2 cycles with `v_in`=0x80 and `en`=1, then release.
   - During reset, all outputs read 0.
   - `v_out` ch0 reads 0, 0, 128, 256 on successive cycles after release.
2. **Wrap period.** Defaults, ch0 `v_in`=128, `en`=1, `glide`=0.
   - `wrap` pulses exactly every 2^25/128 = 262144 cycles.
   - `sq_out` has a 50% duty cycle.
   - ch1 at `v_in`=0 never wraps.
3. **Glide.** `glide`=1, SLEW=16, ch0 `v_in` steps 0 → 128.
   - `inc` reads 16, 32, …, 128 over 8 edges.
   - Stepping `v_in` back to 0 decreases `inc` symmetrically to 0.
4. **Saturation.** F0 = 2^25 − 100, K=1, `v_in`=255.
   - `inc` = 2^25 − 1, not a wrapped value.
   - `wrap` = 1 on every cycle after the second post-reset edge.
5. **Enable / independence.** ch0 `en` toggles 0 for 10 cycles mid-run; ch1 `en`=1 throughout.
   - ch0 `v_out` frozen and ch0 `wrap` = 0 during the gap.
   - ch1 phase advance is unaffected.
6. **Reset mid-glide.** Assert `rst`=0 for one edge while ch0 `inc` = 64 is slewing toward 128.
   - `inc` and `acc` read 0 afterwards.
   - Glide then restarts from 0: 16, 32, ….
